updown_seq: RTL and testbench
=============================

# updown_seq

Run/pause/direction sequencer for the 4-bit up/down counter and its direction-indicator segment display. It turns four debounced push-button levels into a one-cycle step pulse at a programmable rate, a direction level, and a clear pulse, which the counter consumes directly. It watches the counter value so that, in non-wrapping mode, counting stops at 15 or 0. It also drives the up/down sign segments.

## Interface
- DIV, 50_000_000: step period in clk cycles; legal range 2..2^26.
- WRAP, 1: 1 = counter wraps freely; 0 = stop at 15 (up) or 0 (down).
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- btn_start  in  1  debounced, synchronous level; its rising edge requests run.
- btn_stop  in  1  debounced level; its rising edge requests pause or stop.
- btn_dir  in  1  debounced level; its rising edge toggles the direction.
- btn_clr  in  1  debounced level; its rising edge requests a counter clear.
- count  in  4  current counter value, fed back from the datapath.
- step  out  1  one-cycle count-enable pulse to the counter.
- u0d1  out  1  direction to the counter: 0 = up, 1 = down.
- clr  out  1  one-cycle synchronous clear pulse to the counter.
- state  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, LIMIT=11.
- sign_seg  out  7  registered segment pattern; bit 0 is segment a, active-high.

## Operation
- Edge detect: each button is registered into a btn_q flop; edge = btn & ~btn_q.
- Edge priority when several occur in one cycle: clr > stop > start > dir.
- Prescaler: a 26-bit register, pre.
  - In RUN it increments each cycle and returns to 0 after reaching DIV-1.
  - In PAUSE it holds its value.
  - In IDLE and LIMIT it is forced to 0.
- tick = (state==RUN) && (pre==DIV-1).
- FSM transitions:
  - IDLE: start edge -> RUN.
  - RUN: stop edge -> PAUSE. On tick with WRAP=0 and (u0d1=0 && count==15, or u0d1=1 && count==0) -> LIMIT with no step. Any other tick -> step=1 for one cycle.
  - PAUSE: start edge -> RUN, resuming the held pre. Stop edge -> IDLE.
  - LIMIT: dir edge toggles u0d1 and -> RUN with pre=0. Stop edge -> IDLE. Start edge is ignored.
  - Any state: clr edge -> clr=1 for one cycle, state=IDLE, pre=0, u0d1=0. Any step due in that cycle is suppressed.
- Direction: a dir edge in IDLE, RUN or PAUSE toggles u0d1. The new value applies from the next step; pre is not reset.
- A stop edge in the same cycle as a tick: stop wins, step stays 0, state -> PAUSE.
- sign_seg:
  - IDLE: 7'b0000000.
  - Other states with u0d1=0: 7'b0111110.
  - Other states with u0d1=1: 7'b1011110.
  - Updated from next-state and next-u0d1, so it changes in the same cycle as the state and u0d1 outputs.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset values: step=0, clr=0, u0d1=0, state=00, sign_seg=0, pre=0, btn_q=0.
- A button edge seen at clock edge N takes effect at the outputs after edge N+1; clr and state follow at N+1.
- From a start edge in IDLE, the first step occurs after DIV cycles in RUN. Later steps repeat every DIV cycles.
- When RUN resumes from PAUSE, the next step occurs after DIV - pre_held cycles.
- step and clr never exceed one cycle and are never both 1 in the same cycle.
- The counter updates on the edge after step is seen, so the count used in the limit check reflects every prior step.
- An asynchronous reset in mid-run abandons any pending step. Outputs return to reset values without waiting for a clock.

## Test plan
- DIV=4, WRAP=1, start pulse: state goes 00->01; step pulses every 4 cycles. With u0d1=0, sign_seg=7'b0111110; count wraps 15->0.
- DIV=4, WRAP=0, down direction, count=1: exactly one step, then state=11 with step held at 0. A dir edge moves to RUN up, and the next step comes 4 cycles later.
- Stop edge in the same cycle as pre==3: no step, state=10. A later start edge gives the next step 1 cycle after resuming.
- clr and start edges in the same cycle during RUN: clr=1 for exactly one cycle, state=00, u0d1=0, sign_seg=0, no step.
- A dir edge in RUN does not reset pre: the step period is unchanged, and u0d1 and sign_seg flip to 7'b1011110 one cycle later.
- Assert reset asynchronously between clock edges while pre=2 in RUN: all outputs read 0 before the next clk edge. After release, no step occurs without a fresh start edge.

Source files
------------

// File: rtl/updown_seq.sv
`default_nettype none
// ============================================================================
// updown_seq : run/pause/direction sequencer driving the 4-bit up/down counter
//              and its direction sign segments
// Rev 1.0
// ============================================================================
module updown_seq #(
  parameter int DIV  = 50_000_000,
  parameter int WRAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_start,
  input  logic       i_btn_stop,
  input  logic       i_btn_dir,
  input  logic       i_btn_clr,
  input  logic [3:0] i_count,
  output logic       o_step,
  output logic       o_u0d1,
  output logic       o_clr,
  output logic [1:0] o_state,
  output logic [6:0] o_sign_seg
);

  localparam logic [25:0] c_DIV_M1 = 26'(DIV - 1);
  localparam logic [6:0]  c_SEG_UP = 7'b0111110;
  localparam logic [6:0]  c_SEG_DN = 7'b1011110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LIMIT = 2'b11
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [25:0] r_pre, w_pre_nxt;
  logic        r_u0d1, w_u0d1_nxt;
  logic        r_step, w_step_nxt;
  logic        r_clr, w_clr_nxt;
  logic [6:0]  r_seg, w_seg_nxt;
  logic [3:0]  r_btn_q, w_btn, w_edge;
  logic        w_tick, w_at_limit;

  // Bit order: [0]=clr, [1]=stop, [2]=start, [3]=dir (also the priority order)
  assign w_btn      = {i_btn_dir, i_btn_start, i_btn_stop, i_btn_clr};
  assign w_edge     = w_btn & ~r_btn_q;
  assign w_tick     = (r_state == ST_RUN) && (r_pre == c_DIV_M1);
  assign w_at_limit = (WRAP == 0) && (r_u0d1 ? (i_count == 4'h0) : (i_count == 4'hF));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pre   <= '0;
      r_u0d1  <= 1'b0;
      r_step  <= 1'b0;
      r_clr   <= 1'b0;
      r_seg   <= '0;
      r_btn_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_u0d1  <= w_u0d1_nxt;
      r_step  <= w_step_nxt;
      r_clr   <= w_clr_nxt;
      r_seg   <= w_seg_nxt;
      r_btn_q <= w_btn;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_u0d1_nxt  = r_u0d1;
    w_step_nxt  = 1'b0;
    w_clr_nxt   = 1'b0;
    w_seg_nxt   = '0;

    if (w_edge[0]) begin
      w_clr_nxt   = 1'b1;
      w_state_nxt = ST_IDLE;
      w_pre_nxt   = '0;
      w_u0d1_nxt  = 1'b0;
    end else if (w_edge[1]) begin
      // Stopping out of RUN keeps pre so a resume finishes the interrupted period
      if (r_state == ST_RUN) begin
        w_state_nxt = ST_PAUSE;
      end else if (r_state != ST_IDLE) begin
        w_state_nxt = ST_IDLE;
        w_pre_nxt   = '0;
      end
    end else begin
      if (w_edge[2]) begin
        if (r_state == ST_IDLE) begin
          w_state_nxt = ST_RUN;
          w_pre_nxt   = '0;
        end else if (r_state == ST_PAUSE) begin
          w_state_nxt = ST_RUN;
        end
      end else if (w_edge[3]) begin
        w_u0d1_nxt = ~r_u0d1;
        if (r_state == ST_LIMIT) begin
          w_state_nxt = ST_RUN;
          w_pre_nxt   = '0;
        end
      end

      if (r_state == ST_RUN) begin
        if (w_tick) begin
          w_pre_nxt = '0;
          if (w_at_limit) begin
            w_state_nxt = ST_LIMIT;
          end else begin
            w_step_nxt = 1'b1;
          end
        end else begin
          w_pre_nxt = r_pre + 26'd1;
        end
      end
    end

    if (w_state_nxt != ST_IDLE) begin
      w_seg_nxt = w_u0d1_nxt ? c_SEG_DN : c_SEG_UP;
    end
  end

  assign o_step     = r_step;
  assign o_u0d1     = r_u0d1;
  assign o_clr      = r_clr;
  assign o_state    = r_state;
  assign o_sign_seg = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_updown_seq.sv
`default_nettype none
// ============================================================================
// tb_updown_seq : self-checking bench for updown_seq (wrapping and stopping
//                 instances side by side, each with its own counter)
// Rev 1.0
// ============================================================================
module tb_updown_seq;

  localparam int DIV     = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LIMIT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start, btn_stop, btn_dir, btn_clr;
  logic [1:0] step, clr, u0d1;
  logic [1:0] st  [2];
  logic [6:0] seg [2];
  logic [3:0] cnt [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  updown_seq #(.DIV(DIV), .WRAP(1)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .i_btn_start(btn_start), .i_btn_stop(btn_stop), .i_btn_dir(btn_dir), .i_btn_clr(btn_clr),
    .i_count(cnt[0]),
    .o_step(step[0]), .o_u0d1(u0d1[0]), .o_clr(clr[0]), .o_state(st[0]), .o_sign_seg(seg[0])
  );

  updown_seq #(.DIV(DIV), .WRAP(0)) u_dut_stop (
    .clk(clk), .reset(reset),
    .i_btn_start(btn_start), .i_btn_stop(btn_stop), .i_btn_dir(btn_dir), .i_btn_clr(btn_clr),
    .i_count(cnt[1]),
    .o_step(step[1]), .o_u0d1(u0d1[1]), .o_clr(clr[1]), .o_state(st[1]), .o_sign_seg(seg[1])
  );

  // The 4-bit counter each sequencer drives
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset)        cnt[k] <= 4'd0;
      else if (clr[k])  cnt[k] <= 4'd0;
      else if (step[k]) cnt[k] <= u0d1[k] ? cnt[k] - 4'd1 : cnt[k] + 4'd1;
    end
  end

  // Reference model: mode plus cycles remaining until the current period completes
  int       m_mode   [2];
  int       m_remain [2];
  bit       m_dir    [2];
  bit       m_step   [2];
  bit       m_clr    [2];
  bit [3:0] m_prev, m_edge;
  bit       m_due, m_stuck, m_was_run;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_prev = 4'b0;
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = M_IDLE; m_remain[k] = DIV; m_dir[k] = 1'b0;
        m_step[k] = 1'b0;   m_clr[k] = 1'b0;
      end
    end else begin
      m_edge = {btn_dir, btn_start, btn_stop, btn_clr} & ~m_prev;
      m_prev = {btn_dir, btn_start, btn_stop, btn_clr};
      for (int k = 0; k < 2; k++) begin
        m_step[k] = 1'b0;
        m_clr[k]  = 1'b0;
        m_due     = (m_mode[k] == M_RUN) && (m_remain[k] == 1);
        m_stuck   = (k == 1) && (m_dir[k] ? (cnt[k] == 4'd0) : (cnt[k] == 4'd15));
        m_was_run = (m_mode[k] == M_RUN);
        if (m_edge[0]) begin
          m_clr[k] = 1'b1; m_mode[k] = M_IDLE; m_remain[k] = DIV; m_dir[k] = 1'b0;
        end else if (m_edge[1]) begin
          if (m_mode[k] == M_RUN) m_mode[k] = M_PAUSE;
          else if (m_mode[k] != M_IDLE) begin m_mode[k] = M_IDLE; m_remain[k] = DIV; end
        end else begin
          if (m_edge[2]) begin
            if (m_mode[k] == M_IDLE) begin m_mode[k] = M_RUN; m_remain[k] = DIV; end
            else if (m_mode[k] == M_PAUSE) m_mode[k] = M_RUN;
          end else if (m_edge[3]) begin
            m_dir[k] = !m_dir[k];
            if (m_mode[k] == M_LIMIT) begin m_mode[k] = M_RUN; m_remain[k] = DIV; end
          end
          if (m_was_run) begin
            if (m_due) begin
              m_remain[k] = DIV;
              if (m_stuck) m_mode[k] = M_LIMIT;
              else         m_step[k] = 1'b1;
            end else begin
              m_remain[k] = m_remain[k] - 1;
            end
          end
        end
      end
    end
  end

  function automatic logic [11:0] exp_vec(input int k);
    logic [6:0] s;
    s = (m_mode[k] == M_IDLE) ? 7'b0000000 : (m_dir[k] ? 7'b1011110 : 7'b0111110);
    return {m_step[k], m_clr[k], m_dir[k], 2'(m_mode[k]), s};
  endfunction

  function automatic logic [11:0] got_vec(input int k);
    return {step[k], clr[k], u0d1[k], st[k], seg[k]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  // mask bits: [0]=clr, [1]=stop, [2]=start, [3]=dir
  task automatic pulse(input logic [3:0] m);
    btn_clr = m[0]; btn_stop = m[1]; btn_start = m[2]; btn_dir = m[3];
    cyc(1);
    btn_clr = 1'b0; btn_stop = 1'b0; btn_start = 1'b0; btn_dir = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (got_vec(k) !== 12'h000) begin
        n_err++; $display("FAIL reset_state[%0d]: got %h expected %h", k, got_vec(k), 12'h000);
      end
    end
    cyc(2); reset = 1'b0; cyc(2);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (got_vec(k) !== 12'h000) begin
        n_err++; $display("FAIL idle_after_reset[%0d]: got %h expected %h", k, got_vec(k), 12'h000);
      end
    end
  endtask

  task automatic test_run_wrap();
    int n, gap;
    bit wrapped;
    logic [3:0] last;
    pulse(4'b0100);
    n_vec++;
    if (st[0] !== 2'b01 || seg[0] !== 7'b0111110) begin
      n_err++; $display("FAIL run_entry: got state %b seg %b expected 01 0111110", st[0], seg[0]);
    end
    n = 0;
    while (step[0] !== 1'b1 && n < 20) begin cyc(1); n++; end
    n_vec++;
    if (n != DIV) begin n_err++; $display("FAIL first_step_latency: got %0d expected %0d", n, DIV); end
    wrapped = 1'b0; gap = 0; last = cnt[0];
    for (int i = 0; i < 80; i++) begin
      cyc(1); gap++;
      if (last == 4'd15 && cnt[0] == 4'd0) wrapped = 1'b1;
      last = cnt[0];
      if (step[0]) begin
        n_vec++;
        if (gap != DIV) begin n_err++; $display("FAIL step_period: got %0d expected %0d", gap, DIV); end
        gap = 0;
      end
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_err++; $display("FAIL run_model[%0d] cyc %0d: got %h expected %h", k, i, got_vec(k), exp_vec(k));
        end
      end
    end
    n_vec++;
    if (!wrapped) begin n_err++; $display("FAIL count_wrap: got no 15->0 wrap expected wrap"); end
    n_vec++;
    if (st[1] !== 2'b11 || cnt[1] !== 4'd15) begin
      n_err++; $display("FAIL up_limit: got state %b count %0d expected 11 15", st[1], cnt[1]);
    end
  endtask

  task automatic test_limit_down();
    int n, steps;
    pulse(4'b0001);
    n_vec++;
    if (clr[0] !== 1'b1 || st[1] !== 2'b00) begin
      n_err++; $display("FAIL limit_clr: got clr %b state %b expected 1 00", clr[0], st[1]);
    end
    pulse(4'b0100);
    n = 0;
    while (cnt[1] !== 4'd1 && n < 20) begin cyc(1); n++; end
    n_vec++;
    if (cnt[1] !== 4'd1) begin n_err++; $display("FAIL reach_count1: got %0d expected 1", cnt[1]); end
    pulse(4'b1000);
    steps = 0; n = 0;
    while (st[1] !== 2'b11 && n < 30) begin
      cyc(1); n++;
      if (step[1]) steps++;
    end
    n_vec++;
    if (steps != 1 || st[1] !== 2'b11) begin
      n_err++; $display("FAIL down_limit: got steps %0d state %b expected 1 11", steps, st[1]);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      n_vec++;
      if (step[1] !== 1'b0 || st[1] !== 2'b11) begin
        n_err++; $display("FAIL limit_hold: got step %b state %b expected 0 11", step[1], st[1]);
      end
    end
    pulse(4'b1000);
    n_vec++;
    if (st[1] !== 2'b01 || u0d1[1] !== 1'b0 || seg[1] !== 7'b0111110) begin
      n_err++; $display("FAIL limit_dir_exit: got state %b dir %b seg %b expected 01 0 0111110", st[1], u0d1[1], seg[1]);
    end
    n = 0;
    while (step[1] !== 1'b1 && n < 20) begin cyc(1); n++; end
    n_vec++;
    if (n != DIV) begin n_err++; $display("FAIL limit_restart_latency: got %0d expected %0d", n, DIV); end
  endtask

  task automatic test_stop_tick();
    int n;
    pulse(4'b0001);
    pulse(4'b0100);
    n = 0;
    while (step[0] !== 1'b1 && n < 20) begin cyc(1); n++; end
    cyc(DIV - 1);
    pulse(4'b0010);
    n_vec++;
    if (step[0] !== 1'b0 || st[0] !== 2'b10) begin
      n_err++; $display("FAIL stop_on_tick: got step %b state %b expected 0 10", step[0], st[0]);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      n_vec++;
      if (step[0] !== 1'b0 || st[0] !== 2'b10) begin
        n_err++; $display("FAIL pause_hold: got step %b state %b expected 0 10", step[0], st[0]);
      end
    end
    pulse(4'b0100);
    n_vec++;
    if (st[0] !== 2'b01 || step[0] !== 1'b0) begin
      n_err++; $display("FAIL resume: got state %b step %b expected 01 0", st[0], step[0]);
    end
    cyc(1);
    n_vec++;
    if (step[0] !== 1'b1) begin n_err++; $display("FAIL resume_step: got %b expected 1", step[0]); end
  endtask

  task automatic test_clr_start();
    int n;
    pulse(4'b1000);
    n_vec++;
    if (u0d1[0] !== 1'b1) begin n_err++; $display("FAIL dir_before_clr: got %b expected 1", u0d1[0]); end
    n = 0;
    while (step[0] !== 1'b1 && n < 20) begin cyc(1); n++; end
    cyc(DIV - 1);
    pulse(4'b0101);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (got_vec(k) !== 12'h400) begin
        n_err++; $display("FAIL clr_with_start[%0d]: got %h expected %h", k, got_vec(k), 12'h400);
      end
    end
    cyc(1);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (got_vec(k) !== 12'h000) begin
        n_err++; $display("FAIL clr_one_cycle[%0d]: got %h expected %h", k, got_vec(k), 12'h000);
      end
    end
  endtask

  task automatic test_dir_run();
    int n;
    pulse(4'b0100);
    n = 0;
    while (step[0] !== 1'b1 && n < 20) begin cyc(1); n++; end
    n_vec++;
    if (u0d1[0] !== 1'b0) begin n_err++; $display("FAIL dir_pre: got %b expected 0", u0d1[0]); end
    pulse(4'b1000);
    n = 1;
    n_vec++;
    if (u0d1[0] !== 1'b1 || seg[0] !== 7'b1011110) begin
      n_err++; $display("FAIL dir_flip: got dir %b seg %b expected 1 1011110", u0d1[0], seg[0]);
    end
    while (step[0] !== 1'b1 && n < 20) begin cyc(1); n++; end
    n_vec++;
    if (n != DIV) begin n_err++; $display("FAIL dir_period: got %0d expected %0d", n, DIV); end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (step[0] !== 1'b1 && n < 20) begin cyc(1); n++; end
    cyc(2);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (got_vec(k) !== 12'h000) begin
        n_err++; $display("FAIL async_reset[%0d]: got %h expected %h", k, got_vec(k), 12'h000);
      end
    end
    @(negedge clk);
    cyc(1);
    reset = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      cyc(1);
      n_vec++;
      if (step !== 2'b00 || st[0] !== 2'b00 || st[1] !== 2'b00) begin
        n_err++; $display("FAIL post_reset_idle: got step %b states %b %b expected 00 00 00", step, st[0], st[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) btn_clr   = ~btn_clr;
      if ($urandom_range(0, 23) == 0) btn_stop  = ~btn_stop;
      if ($urandom_range(0, 5)  == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 15) == 0) btn_dir   = ~btn_dir;
      cyc(1);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_err++; $display("FAIL random[%0d] cyc %0d: got %h expected %h", k, i, got_vec(k), exp_vec(k));
        end
      end
    end
    btn_clr = 1'b0; btn_stop = 1'b0; btn_start = 1'b0; btn_dir = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    btn_start = 1'b0; btn_stop = 1'b0; btn_dir = 1'b0; btn_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_run_wrap();
    test_limit_down();
    test_stop_tick();
    test_clr_start();
    test_dir_run();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
